// File: rtl/mmu_drain.sv
// Result-side drain: deskews the array's bottom-row columns into aligned vectors and buffers them
// in a FWFT FIFO with credit-based in_ready. Define MMU_DRAIN_RELU_EN to clamp negatives at write.
module mmu_drain #(
  parameter int unsigned SIZE       = 2,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACC_WIDTH-1:0] acc_in   [SIZE],
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data [SIZE],
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + SIZE) + 1;

  typedef logic [ACC_WIDTH-1:0] word_t;

  word_t           mem_q [FIFO_DEPTH][SIZE];
  word_t           aligned [SIZE];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, inflight;
  logic            overflow_q;
  logic            accept, drop, wr_en, pop;

  function automatic word_t clamp(word_t v);
`ifdef MMU_DRAIN_RELU_EN
    return v[ACC_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credits cover both buffered and in-flight vectors, so a write can never find the FIFO full.
  assign in_ready  = (count_q + inflight) < CntW'(FIFO_DEPTH);
  assign accept    = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign overflow  = overflow_q;

  always_comb begin
    for (int c = 0; c < int'(SIZE); c++) out_data[c] = mem_q[rd_ptr_q][c];
  end

  // Column c arrives c cycles late, so it needs SIZE-1-c stages to line up with the last column.
  for (genvar c = 0; c < int'(SIZE); c++) begin : g_col
    if (c == int'(SIZE) - 1) begin : g_direct
      assign aligned[c] = acc_in[c];
    end else begin : g_dly
      localparam int N = int'(SIZE) - 1 - c;
      word_t dly_q [N];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < N; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= acc_in[c];
          for (int k = 1; k < N; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned[c] = dly_q[N-1];
    end
  end

  if (SIZE > 1) begin : g_vline
    localparam int unsigned VW = SIZE - 1;
    logic [VW-1:0] vline_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vline_q <= '0;
      else     vline_q <= (vline_q << 1) | VW'(accept);
    end
    assign wr_en = vline_q[VW-1];
    always_comb begin
      inflight = '0;
      for (int k = 0; k < int'(VW); k++) inflight = inflight + CntW'(vline_q[k]);
    end
  end else begin : g_novline
    assign wr_en    = accept;
    assign inflight = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int d = 0; d < int'(FIFO_DEPTH); d++) begin
        for (int c = 0; c < int'(SIZE); c++) mem_q[d][c] <= '0;
      end
    end else begin
      if (wr_en) begin
        for (int c = 0; c < int'(SIZE); c++) mem_q[wr_ptr_q][c] <= clamp(aligned[c]);
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

endmodule
